uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, ticks per bit period (even, >=8).
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity and 1 selects odd parity.
REQ-004 SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_tick, input, 1, one-cycle oversample strobe from the baud generator.
REQ-007 SHALL have port i_rx, input, 1, asynchronous serial line; idle high.
REQ-008 SHALL have port o_data, output, DATA_BITS, last received payload.
REQ-009 SHALL have port o_valid, output, 1, one-cycle pulse when o_data updates.
REQ-010 SHALL have port o_frame_err, output, 1, one-cycle pulse with o_valid when the stop bit samples 0.
REQ-011 SHALL have port o_parity_err, output, 1, one-cycle pulse with o_valid when parity mismatches (UART_PARITY_EN only).
REQ-012 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL synchronise i_rx through two flops (reset value 1); all decisions use the synchronised value.
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-015 SHALL advance the tick counter and bit sampling only in cycles where i_tick=1.
REQ-016 IDLE: synchronised rx=0 SHALL move to START and clear the tick counter, with no tick required.
REQ-017 START: on tick OVERSAMPLE/2, rx=0 SHALL move to DATA with counter cleared, and rx=1 SHALL return to IDLE with no output pulse (glitch reject).
REQ-018 DATA: every OVERSAMPLE ticks SHALL sample one bit LSB-first into a shift register, and after DATA_BITS samples SHALL go to PARITY (macro on) or STOP (macro off).
REQ-019 PARITY: after OVERSAMPLE ticks SHALL sample the parity bit and compare it against the XOR of the payload, inverted when PARITY_ODD=1.
REQ-020 STOP: after OVERSAMPLE ticks SHALL sample the stop bit; stop=1 returns to IDLE and stop=0 goes to WAIT_IDLE.
REQ-021 o_valid SHALL pulse for exactly one cycle, in the cycle after the stop-sampling tick edge, and o_data SHALL update in that same cycle (1-clock latency).
REQ-022 On stop=0, o_valid and o_frame_err SHALL pulse together and o_data SHALL still update.
REQ-023 WAIT_IDLE SHALL remain until synchronised rx=1, then go to IDLE, so a held-low (break) line never re-triggers a start.
REQ-024 o_data SHALL hold its value between o_valid pulses.
REQ-025 The tick counter SHALL be ceil(log2(OVERSAMPLE)) bits and SHALL wrap to 0 at each bit boundary.
REQ-026 A falling edge on rx in the cycle STOP exits to IDLE SHALL be detected on the next cycle, with no frame lost for back-to-back frames.

Reset
REQ-027 While i_rst_n=0: state=IDLE; counters, shift register and o_data = 0; o_valid, o_frame_err, o_parity_err, o_busy = 0; sync flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a new falling edge.

Configuration
REQ-029 With macro UART_PARITY_EN defined, the PARITY state and o_parity_err port SHALL exist.
REQ-030 With UART_PARITY_EN undefined, the PARITY state and o_parity_err port SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum type and default constants for DATA_BITS and OVERSAMPLE.
REQ-032 The two-flop synchroniser SHALL be a sub-module named uart_sync, with reset value 1.

Verification
REQ-033 With OVERSAMPLE=16, a tick every 4 clocks and macro on, sending 0xA5 with even parity 0 and stop 1 -> o_data=0xA5, one o_valid pulse, both error outputs 0.
REQ-034 rx low for 4 ticks, then high -> START returns to IDLE, no o_valid, o_busy falls.
REQ-035 Sending 0x3C with stop bit 0, then the line held low for 40 ticks -> o_valid and o_frame_err pulse together, state stays WAIT_IDLE until rx=1, no second frame.
REQ-036 Sending 0x01 with parity bit 0 (even) -> o_valid and o_parity_err pulse, o_data=0x01.
REQ-037 Back-to-back frames 0x00 then 0xFF with no idle gap -> exactly two o_valid pulses with the correct data, in order.
REQ-038 i_rst_n asserted during data bit 3, then released, then 0x55 sent -> no pulse for the aborted frame; o_data=0x55 after the following frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: tick/line inputs and received-word outputs.
// o_parity_err is present only when UART_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DEFAULT_DATA_BITS
);

  logic                 i_tick;
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
`ifdef UART_PARITY_EN
  logic                 o_parity_err;
`endif
  logic                 o_busy;

  modport slave (
    input  i_tick, i_rx,
    output o_data, o_valid, o_frame_err,
`ifdef UART_PARITY_EN
    output o_parity_err,
`endif
    output o_busy
  );

  modport master (
    output i_tick, i_rx,
    input  o_data, o_valid, o_frame_err,
`ifdef UART_PARITY_EN
    input  o_parity_err,
`endif
    input  o_busy
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
module uart_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/[parity]/stop framing, break-safe.
// Optional parity checking is built when UART_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx: unsupported parameter set");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  logic rx_s;
  logic bit_end;

  uart_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.i_rx),
    .o_q     (rx_s)
  );

  assign bit_end = bus.i_tick && (cnt_q == FULL_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    // Counter wraps at every bit boundary while a frame is in flight.
    if (bus.i_tick && state_q != ST_IDLE && state_q != ST_WAIT_IDLE) begin
      cnt_d = (cnt_q == FULL_LAST) ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (bus.i_tick && cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          par_bad_d = rx_s ^ (^shift_q) ^ ODD_BIT;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          ferr_d  = !rx_s;
`ifdef UART_PARITY_EN
          perr_d  = par_bad_q;
`endif
          // A low stop bit may be a break; wait for the line to recover.
          state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
`ifdef UART_PARITY_EN
  assign bus.o_parity_err = perr_q;
`endif
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule
